// File: rtl/fair_selector.sv
// Bounded-fair scheduler for the mutex models: follows choice/want_pause, but forces any
// process whose age reaches BOUND and caps pause runs at PMAX cycles.
module fair_selector #(
    parameter int HIPROC = 2,
    parameter int SELMSB = 1,
    parameter int BOUND  = 4,
    parameter int PMAX   = 3,
    parameter int CNTMSB = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SELMSB:0]   choice,
    input  logic              want_pause,
    output logic [SELMSB:0]   select,
    output logic              pause,
    output logic              forced,
    output logic              round_done
);

    localparam int NPROC = HIPROC + 1;

    typedef logic [CNTMSB:0] cnt_t;
    typedef logic [SELMSB:0] sel_t;

    localparam cnt_t BOUND_V  = cnt_t'(BOUND);
    localparam cnt_t PMAX_V   = cnt_t'(PMAX);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam sel_t HIPROC_V = sel_t'(HIPROC);

    cnt_t            age_q [NPROC];
    cnt_t            age_d [NPROC];
    cnt_t            pcnt_q, pcnt_d;
    logic [HIPROC:0] seen_q, seen_d;
    sel_t            select_q, select_d;
    logic            pause_q, pause_d;
    logic            forced_q, forced_d;
    logic            round_done_q, round_done_d;

    logic            found;
    logic [HIPROC:0] next_seen;

    always_comb begin
        select_d     = '0;
        forced_d     = 1'b0;
        found        = 1'b0;
        next_seen    = seen_q;
        seen_d       = seen_q;
        round_done_d = 1'b0;
        pause_d      = 1'b0;
        pcnt_d       = '0;

        // The age rule wins over choice; the lowest expired index goes first.
        for (int p = 0; p < NPROC; p++) begin
            if (!found && (age_q[p] >= BOUND_V)) begin
                found    = 1'b1;
                select_d = sel_t'(p);
                forced_d = 1'b1;
            end
        end
        if (!found) begin
            if (choice > HIPROC_V) begin
                select_d = '0;
            end else begin
                select_d = choice;
            end
        end

        for (int p = 0; p < NPROC; p++) begin
            age_d[p] = age_q[p];
            if (select_d == sel_t'(p)) begin
                age_d[p]     = '0;
                next_seen[p] = 1'b1;
            end else if (age_q[p] >= BOUND_V) begin
                age_d[p] = BOUND_V;
            end else begin
                age_d[p] = age_q[p] + CNT_ONE;
            end
        end

        // The selection that completes the mask is credited to the round it closes.
        if (&next_seen) begin
            round_done_d = 1'b1;
            seen_d       = '0;
        end else begin
            round_done_d = 1'b0;
            seen_d       = next_seen;
        end

        if (want_pause && (pcnt_q < PMAX_V)) begin
            pause_d = 1'b1;
            pcnt_d  = pcnt_q + CNT_ONE;
        end else begin
            pause_d = 1'b0;
            pcnt_d  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NPROC; p++) begin
                age_q[p] <= '0;
            end
            pcnt_q       <= '0;
            seen_q       <= '0;
            select_q     <= '0;
            pause_q      <= 1'b0;
            forced_q     <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            for (int p = 0; p < NPROC; p++) begin
                age_q[p] <= age_d[p];
            end
            pcnt_q       <= pcnt_d;
            seen_q       <= seen_d;
            select_q     <= select_d;
            pause_q      <= pause_d;
            forced_q     <= forced_d;
            round_done_q <= round_done_d;
        end
    end

    assign select     = select_q;
    assign pause      = pause_q;
    assign forced     = forced_q;
    assign round_done = round_done_q;

endmodule

// File: tb/tb_fair_selector.sv
// Scoreboard bench for fair_selector: the driver queues hand-computed expectations per cycle,
// a separate monitor pops and compares them after each posedge.
module tb_fair_selector;

    logic       clock;
    logic       reset;
    logic [1:0] choice;
    logic       want_pause;
    logic [1:0] select;
    logic       pause;
    logic       forced;
    logic       round_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic       pau;
        logic       frc;
        logic       rnd;
    } exp_t;

    exp_t exp_q[$];

    fair_selector #(
        .HIPROC(2),
        .SELMSB(1),
        .BOUND (4),
        .PMAX  (3),
        .CNTMSB(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .choice    (choice),
        .want_pause(want_pause),
        .select    (select),
        .pause     (pause),
        .forced    (forced),
        .round_done(round_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs for the next posedge, queue its expected result.
    task automatic step(input int ch, input int wp, input int es, input int ep, input int ef,
                        input int er);
        exp_t e;
        choice     = 2'(ch);
        want_pause = wp[0];
        e.sel = 2'(es);
        e.pau = ep[0];
        e.frc = ef[0];
        e.rnd = er[0];
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        choice     = 2'd0;
        want_pause = 1'b0;
        @(negedge clock);
        check("reset_select", int'(select), 0);
        check("reset_pause", int'(pause), 0);
        check("reset_forced", int'(forced), 0);
        check("reset_round_done", int'(round_done), 0);
        reset = 1'b0;
    endtask

    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("select", int'(select), int'(e.sel));
            check("pause", int'(pause), int'(e.pau));
            check("forced", int'(forced), int'(e.frc));
            check("round_done", int'(round_done), int'(e.rnd));
        end
    end

    initial begin
        reset      = 1'b1;
        choice     = 2'd0;
        want_pause = 1'b0;
        @(negedge clock);
        do_reset();

        // choice held at 0: indices 1 and 2 expire together and are served in order
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 2, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0);

        // round-robin choice with constant pause request
        do_reset();
        step(0, 1, 0, 1, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        step(2, 1, 2, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        step(2, 1, 2, 1, 0, 1);
        step(0, 1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0, 0);

        // out-of-range choice credits index 0; pause run broken by a zero request
        do_reset();
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(3, 1, 0, 1, 0, 0);
        step(1, 1, 2, 1, 1, 1);
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 2, 0, 1, 1);

        // asynchronous reset mid-cycle while pause=1, select=2, age[1]=3
        do_reset();
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        step(2, 1, 2, 1, 0, 0);
        #1;
        reset = 1'b1;
        #1;
        check("async_select", int'(select), 0);
        check("async_pause", int'(pause), 0);
        check("async_forced", int'(forced), 0);
        check("async_round_done", int'(round_done), 0);
        @(negedge clock);
        reset      = 1'b0;
        choice     = 2'd0;
        want_pause = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 2, 0, 1, 1);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clock);
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fair_selector.md
# fair_selector

Upstream scheduler for the parameterized mutual-exclusion models: produces the per-cycle `select` and `pause` inputs those models consume. It replaces a free primary input with a bounded-fair choice. Every process index is selected at least once within a fixed window, and `pause` never holds for more than a fixed run. Within those limits it follows nondeterministic `choice` / `want_pause` inputs, so model checking still explores all fair interleavings.

## Interface
- `HIPROC`, default 2: highest process index; indices start at 0.
- `SELMSB`, default 1: MSB of process-index signals; must represent `HIPROC+1`.
- `BOUND`, default 4: age at which a process is force-selected; must be ≥ `HIPROC+1`.
- `PMAX`, default 3: maximum consecutive cycles with `pause`=1; must be ≥ 1.
- `CNTMSB`, default 2: MSB of the age and pause counters; must represent `max(BOUND, PMAX)`.

Ports:
- `clock`  in  1: single clock; all state changes on posedge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `choice`  in  `SELMSB+1`: nondeterministic preferred process index.
- `want_pause`  in  1: nondeterministic pause request.
- `select`  out  `SELMSB+1`: registered process index to run; always ≤ `HIPROC`.
- `pause`  out  1: registered pause to the mutex model.
- `forced`  out  1: registered; 1 when `select` came from the age rule, not from `choice`.
- `round_done`  out  1: registered one-cycle pulse when every index has been selected since the last pulse.

## Operation
- State:
  - `age[0..HIPROC]`, each `CNTMSB+1` bits: counts posedges since that index was last output.
  - `pcnt`: count of consecutive `pause`=1 outputs.
  - `seen`: `HIPROC+1`-bit mask of indices selected in the current round.
  - The four registered outputs.
- Selection at each posedge, evaluated on pre-edge state:
  - If any `age[p]` ≥ `BOUND`: `select` ← lowest such p; `forced` ← 1. This applies even when `choice` equals p.
  - Else if `choice` > `HIPROC`: `select` ← 0; `forced` ← 0.
  - Else: `select` ← `choice`; `forced` ← 0.
- Age update for the newly selected index q:
  - `age[q]` ← 0.
  - Every other index: `age[p]` ← min(`age[p]`+1, `BOUND`). The counter saturates and never wraps.
- Simultaneous expiry: several ages at `BOUND` are served in ascending index order, one per cycle. The others stay saturated until served.
- Fairness guarantee: each index appears on `select` at least once in every `BOUND+HIPROC+1` consecutive outputs.
- Pause:
  - If `want_pause`=1 and `pcnt` < `PMAX`: `pause` ← 1; `pcnt` ← `pcnt`+1.
  - Otherwise: `pause` ← 0; `pcnt` ← 0.
  - `pause` is independent of selection.
- Round tracking:
  - `next_seen` = `seen` | onehot(q).
  - If `next_seen` is all ones: `round_done` ← 1 and `seen` ← 0. The completing selection belongs to the finished round.
  - Else: `round_done` ← 0 and `seen` ← `next_seen`.
- Reset, including mid-operation: asynchronously sets
  - `select`=0, `pause`=0, `forced`=0, `round_done`=0
  - all `age`=0, `pcnt`=0, `seen`=0
  
  After reset release, index 0 is not credited in `seen` until it is actually selected.

## Timing
- Latency: 1 cycle. `choice` / `want_pause` sampled at posedge k appear on outputs after posedge k.
- No handshake. The consumer samples `select`/`pause` at every posedge.
- All outputs are registers; no combinational input-to-output path.
- `round_done` and `forced` are valid in the same cycle as the `select` they describe.
- Out-of-range `choice` counts as a normal selection of index 0 for ages and `seen`.

## Test plan
- HIPROC=2, BOUND=4; reset then `choice`=0 constantly:
  - `select` after posedges 1..7 = 0,0,0,0,1,2,0.
  - `forced`=1 only at posedges 5 and 6.
  - `round_done`=1 only after posedge 6.
- `want_pause`=1 constantly, PMAX=3 -> `pause` = 1,1,1,0,1,1,1,0.
- `want_pause` pattern 1,1,0,1,1,1,1 -> `pause` = 1,1,0,1,1,1,0. Confirms `pcnt` clears on a 0 request.
- `choice`=3 (out of range) with HIPROC=2 -> `select`=0, `forced`=0, `age[0]` reset to 0.
- `choice` cycling 0,1,2 -> `forced` never asserts; `round_done` pulses after every third posedge.
- Assert `reset` asynchronously mid-cycle while `pause`=1 and `age[1]`=3:
  - All outputs read 0 before the next posedge.
  - After release with `choice`=0, the first force of index 1 occurs at posedge 5.
